// File: rtl/rst_mgmt.sv
// rst_mgmt: PLL-lock-qualified reset sequencer for an Ethernet PHY and MAC/AXI core.
// Optional soft-reset request input enabled by defining ETH_RST_SOFT_REQ_EN.
module rst_mgmt #(
   parameter int LOCK_STABLE_CYCLES = 16,
   parameter int PHY_RST_CYCLES     = 1024,
   parameter int PHY_WAIT_CYCLES    = 2048
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       clk_locked,
`ifdef ETH_RST_SOFT_REQ_EN
   input  logic       sw_rst_req,
`endif
   output logic       phy_rst_n,
   output logic       rst_core,
   output logic       rst_ready,
   output logic [1:0] rst_state
);
   localparam int MAX_AB = (LOCK_STABLE_CYCLES > PHY_RST_CYCLES) ? LOCK_STABLE_CYCLES : PHY_RST_CYCLES;
   localparam int MAXC   = (MAX_AB > PHY_WAIT_CYCLES) ? MAX_AB : PHY_WAIT_CYCLES;
   localparam int CW     = $clog2(MAXC + 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] RST_LAST  = CW'(PHY_RST_CYCLES - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(PHY_WAIT_CYCLES - 1);
   typedef enum logic [1:0] {S_LOCK = 2'd0, S_PHY_RST = 2'd1, S_PHY_WAIT = 2'd2, S_RUN = 2'd3} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt, w_cnt;
   logic          r_sync1, r_lock_sync, w_soft, w_expire;
   logic          r_phy_rst_n, r_rst_core, r_rst_ready;
`ifdef ETH_RST_SOFT_REQ_EN
   assign w_soft = sw_rst_req;
`else
   assign w_soft = 1'b0;
`endif
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_sync1     <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_sync1     <= clk_locked;
         r_lock_sync <= r_sync1;
      end
   end
   always_comb begin
      w_next   = r_state;
      w_cnt    = (r_state == S_RUN) ? r_cnt : r_cnt + CW'(1);
      w_expire = (r_state == S_LOCK)     ? (r_cnt == LOCK_LAST) :
                 (r_state == S_PHY_RST)  ? (r_cnt == RST_LAST)  :
                 (r_state == S_PHY_WAIT) ? (r_cnt == WAIT_LAST) : 1'b0;
      // Lock loss outranks soft request, which outranks normal expiry
      if (r_state == S_LOCK) begin
         if (!r_lock_sync) begin
            w_cnt = '0;
         end else if (w_expire) begin
            w_next = S_PHY_RST;
            w_cnt  = '0;
         end
      end else if (!r_lock_sync) begin
         w_next = S_LOCK;
         w_cnt  = '0;
      end else if (w_soft) begin
         w_next = S_PHY_RST;
         w_cnt  = '0;
      end else if (w_expire) begin
         w_next = state_t'(r_state + 2'd1);
         w_cnt  = '0;
      end
   end
   // Outputs are decoded from the next state so they flip on the state-entry edge
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= S_LOCK;
         r_cnt       <= '0;
         r_phy_rst_n <= 1'b0;
         r_rst_core  <= 1'b1;
         r_rst_ready <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt;
         r_phy_rst_n <= (w_next == S_PHY_WAIT) || (w_next == S_RUN);
         r_rst_core  <= (w_next != S_RUN);
         r_rst_ready <= (w_next == S_RUN);
      end
   end
   assign phy_rst_n = r_phy_rst_n;
   assign rst_core  = r_rst_core;
   assign rst_ready = r_rst_ready;
   assign rst_state = r_state;
endmodule

// File: doc/rst_mgmt.md
RST_MGMT -- requirements
Module: rst_mgmt

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 16, consecutive synchronized-lock cycles required before the sequence starts (>=1).
REQ-002 SHALL have parameter PHY_RST_CYCLES, default 1024, cycles PHY reset is held asserted (>=1).
REQ-003 SHALL have parameter PHY_WAIT_CYCLES, default 2048, cycles between PHY reset release and core reset release (>=1).
REQ-004 SHALL have port clk_in, input, 1, single clock: the PLL output clock; all logic SHALL run in this domain.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clk_locked, input, 1, PLL lock, asynchronous to clk_in.
REQ-007 SHALL have port phy_rst_n, output, 1, active-low Ethernet PHY reset.
REQ-008 SHALL have port rst_core, output, 1, active-high reset for the MAC/AXI logic; asynchronous assertion, synchronous deassertion.
REQ-009 SHALL have port rst_ready, output, 1, high only while the sequence is complete.
REQ-010 SHALL have port rst_state, output, 2, current FSM state for debug (0 S_LOCK, 1 S_PHY_RST, 2 S_PHY_WAIT, 3 S_RUN).

Function
REQ-011 SHALL pass clk_locked through a 2-flop synchronizer (lock_sync); all FSM decisions SHALL use lock_sync only.
REQ-012 SHALL use a single down/up cycle counter sized to the maximum of the three parameters, cleared on every state transition.
REQ-013 In S_LOCK, the counter SHALL increment while lock_sync=1 and clear while lock_sync=0; on the cycle lock_sync=1 with counter=LOCK_STABLE_CYCLES-1, next state SHALL be S_PHY_RST.
REQ-014 S_PHY_RST SHALL last exactly PHY_RST_CYCLES cycles, then advance to S_PHY_WAIT.
REQ-015 S_PHY_WAIT SHALL last exactly PHY_WAIT_CYCLES cycles, then advance to S_RUN.
REQ-016 S_RUN SHALL be held indefinitely while lock_sync=1.
REQ-017 In any state other than S_LOCK, lock_sync=0 SHALL force S_LOCK on the next edge, with the counter cleared; this lock-loss check SHALL take priority over counter expiry on the same cycle.
REQ-018 All outputs SHALL be registered and SHALL change on the same edge on which the state register enters the corresponding state:
- phy_rst_n=0 in S_LOCK/S_PHY_RST, 1 otherwise
- rst_core=0 only in S_RUN
- rst_ready=1 only in S_RUN
REQ-019 phy_rst_n SHALL therefore rise exactly PHY_WAIT_CYCLES cycles before rst_core falls.
REQ-020 No output SHALL glitch; all outputs SHALL be driven directly from flops.

Reset
REQ-021 rst_in=1 SHALL asynchronously force: state S_LOCK, counter 0, synchronizer flops 0, phy_rst_n=0, rst_core=1, rst_ready=0, rst_state=0.
REQ-022 After rst_in deasserts, the full sequence SHALL restart from S_LOCK; rst_in asserted mid-sequence SHALL abort it immediately, without waiting for a clock edge.

Configuration
REQ-023 Macro ETH_RST_SOFT_REQ_EN SHALL control an optional soft-reset request.
REQ-024 When ETH_RST_SOFT_REQ_EN is defined, the block SHALL have input port sw_rst_req (1 bit, synchronous to clk_in, level).
- sw_rst_req=1 in S_PHY_RST, S_PHY_WAIT or S_RUN SHALL force S_PHY_RST on the next edge, with the counter cleared.
- sw_rst_req held high SHALL keep the block in S_PHY_RST.
- lock loss SHALL take priority over sw_rst_req.
- sw_rst_req SHALL be ignored in S_LOCK.
REQ-025 When ETH_RST_SOFT_REQ_EN is not defined, the sw_rst_req port and its logic SHALL be absent; behaviour SHALL be exactly REQ-011..REQ-020.

Verification (bench parameters LOCK_STABLE_CYCLES=4, PHY_RST_CYCLES=8, PHY_WAIT_CYCLES=6)
REQ-026 Power-up: hold rst_in=1 for 5 cycles with clk_locked=1 -> phy_rst_n=0, rst_core=1, rst_ready=0 throughout; after release:
- S_PHY_RST is entered 2+4 cycles later.
- phy_rst_n rises 8 cycles after that.
- rst_core falls and rst_ready rises 6 cycles after that.
REQ-027 Lock bounce: clk_locked high 3 cycles, low 1 cycle, then high -> counter restarts; the sequence starts only after 4 consecutive lock_sync=1 cycles.
REQ-028 Lock loss in S_RUN: drop clk_locked for 1 cycle -> 2 cycles later rst_core=1, phy_rst_n=0, rst_ready=0, rst_state=0; the full sequence then repeats.
REQ-029 Lock loss on the final cycle of S_PHY_WAIT -> next state is S_LOCK, not S_RUN; rst_core never deasserts.
REQ-030 Async abort: assert rst_in mid-cycle during S_PHY_WAIT -> phy_rst_n=0 and rst_core=1 before the next clk_in edge.
REQ-031 ETH_RST_SOFT_REQ_EN defined: pulse sw_rst_req for 1 cycle in S_RUN -> next edge rst_state=1 and phy_rst_n=0; rst_core is reasserted for exactly 8+6 cycles, then S_RUN resumes. With the macro undefined, the bench SHALL confirm the port is absent.
